// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : Port bundle between ID-stage branch issue and the branch
//                resolution stage (operands, control, results, statistics).
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int WIDTH  = 32,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) ();
    logic              stall;
    logic              flush;
    logic              br_valid;
    logic [2:0]        br_op;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [PC_W-1:0]   pc;
    logic [15:0]       offset;
    logic              pred_in;
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_taken;
    logic              res_valid;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic              zero;
    logic              one;
    logic              mispredict;
    logic              illegal_op;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] miss_count;

    // Issuing side: drives branches, observes resolution
    modport master (
        output stall, flush, br_valid, br_op, op1, op2, pc, offset, pred_in, lookup_pc,
        input  pred_taken, res_valid, taken, target, zero, one, mispredict, illegal_op,
               br_count, miss_count
    );

    // Resolution unit side
    modport slave (
        input  stall, flush, br_valid, br_op, op1, op2, pc, offset, pred_in, lookup_pc,
        output pred_taken, res_valid, taken, target, zero, one, mispredict, illegal_op,
               br_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Registered MIPS branch resolution (BEQ/BNE/BLTZ/BGEZ/BLEZ/
//                BGTZ), target computation, optional 2-bit BHT and saturating
//                branch / mispredict statistics.
//                Define BRANCH_PRED_EN to build the branch history table;
//                otherwise prediction is static not-taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int STAT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int c_IDX_W = $clog2(BHT_DEPTH);

    logic              r_resValid;
    logic              r_taken;
    logic [PC_W-1:0]   r_target;
    logic              r_zero;
    logic              r_one;
    logic              r_mispredict;
    logic              r_illegal;
    logic [STAT_W-1:0] r_brCount;
    logic [STAT_W-1:0] r_missCount;

    logic              w_brTaken;
    logic              w_illegal;
    logic              w_capture;
    logic              w_missNext;
    logic              w_neg;
    logic              w_isZero;
    logic [PC_W-1:0]   w_target;
    logic              w_unusedBits;

    assign w_neg     = bus.op1[WIDTH-1];
    assign w_isZero  = (bus.op1 == '0);
    assign w_illegal = bus.br_op[2] & bus.br_op[1];
    // Flush outranks stall; either one blocks capture and all state updates
    assign w_capture = bus.br_valid & ~bus.flush & ~bus.stall;
    assign w_target  = bus.pc + PC_W'(4) + {{(PC_W-18){bus.offset[15]}}, bus.offset, 2'b00};

    // Branch condition evaluation on signed operands; illegal ops resolve not-taken
    always_comb begin
        w_brTaken = 1'b0;
        case (bus.br_op)
            3'd0:    w_brTaken = (bus.op1 == bus.op2);
            3'd1:    w_brTaken = (bus.op1 != bus.op2);
            3'd2:    w_brTaken = w_neg;
            3'd3:    w_brTaken = ~w_neg;
            3'd4:    w_brTaken = w_neg | w_isZero;
            3'd5:    w_brTaken = ~w_neg & ~w_isZero;
            default: w_brTaken = 1'b0;
        endcase
    end

`ifdef BRANCH_PRED_EN
    logic [1:0]         r_bht [BHT_DEPTH];
    logic [c_IDX_W-1:0] w_updIdx;
    logic [c_IDX_W-1:0] w_lookIdx;

    assign w_updIdx     = bus.pc[c_IDX_W+1:2];
    assign w_lookIdx    = bus.lookup_pc[c_IDX_W+1:2];
    // Registered array read: a same-cycle update is seen on the following cycle
    assign bus.pred_taken = r_bht[w_lookIdx][1];
    assign w_missNext   = w_brTaken ^ bus.pred_in;
    assign w_unusedBits = ^{bus.lookup_pc[PC_W-1:c_IDX_W+2], bus.lookup_pc[1:0]};

    // 2-bit saturating counters, trained only by legal captured branches
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else if (w_capture && !w_illegal) begin
            if (w_brTaken && r_bht[w_updIdx] != 2'b11)
                r_bht[w_updIdx] <= r_bht[w_updIdx] + 2'b01;
            else if (!w_brTaken && r_bht[w_updIdx] != 2'b00)
                r_bht[w_updIdx] <= r_bht[w_updIdx] - 2'b01;
        end
    end
`else
    // Static not-taken: every taken branch is a mispredict
    assign bus.pred_taken = 1'b0;
    assign w_missNext     = w_brTaken;
    assign w_unusedBits   = ^{bus.pred_in, bus.lookup_pc};
`endif

    // Result pipeline register with flush/stall priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resValid   <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_zero       <= 1'b0;
            r_one        <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (bus.flush) begin
            r_resValid   <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!bus.stall) begin
            r_resValid <= bus.br_valid;
            if (bus.br_valid) begin
                r_taken      <= w_brTaken;
                r_target     <= w_target;
                r_zero       <= (bus.op1 == bus.op2);
                r_one        <= (bus.op1 != bus.op2);
                r_mispredict <= w_missNext;
                r_illegal    <= w_illegal;
            end else begin
                r_taken      <= 1'b0;
                r_mispredict <= 1'b0;
                r_illegal    <= 1'b0;
            end
        end
    end

    // Saturating statistics; illegal ops still count as resolved branches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brCount   <= '0;
            r_missCount <= '0;
        end else if (w_capture) begin
            if (r_brCount != '1)
                r_brCount <= r_brCount + STAT_W'(1);
            if (w_missNext && r_missCount != '1)
                r_missCount <= r_missCount + STAT_W'(1);
        end
    end

    assign bus.res_valid  = r_resValid;
    assign bus.taken      = r_taken;
    assign bus.target     = r_target;
    assign bus.zero       = r_zero;
    assign bus.one        = r_one;
    assign bus.mispredict = r_mispredict;
    assign bus.illegal_op = r_illegal;
    assign bus.br_count   = r_brCount;
    assign bus.miss_count = r_missCount;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Scoreboard bench for branch_resolve_unit; directed vectors
//                with hand-computed outcome and target.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
    localparam int WIDTH     = 32;
    localparam int PC_W      = 32;
    localparam int BHT_DEPTH = 16;
    localparam int STAT_W    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(WIDTH), .PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    branch_resolve_unit #(
        .WIDTH(WIDTH), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic        zero;
        logic        one;
        logic        miss;
        logic        ill;
        logic        pred;
        logic [15:0] brc;
        logic [15:0] mc;
    } exp_t;

    exp_t q[$];
    int   nCmp  = 0;
    int   nFail = 0;

    // Reference state for one-cycle-latency outputs
    logic        mValid, mTaken, mZero, mOne, mMiss, mIll;
    logic [31:0] mTarget;
    logic [15:0] mBr, mMc;
    logic [1:0]  mBht [BHT_DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot(input logic [31:0] look);
        exp_t e;
        e.valid  = mValid;
        e.taken  = mTaken;
        e.target = mTarget;
        e.zero   = mZero;
        e.one    = mOne;
        e.miss   = mMiss;
        e.ill    = mIll;
        e.brc    = mBr;
        e.mc     = mMc;
`ifdef BRANCH_PRED_EN
        e.pred   = mBht[look[5:2]][1];
`else
        e.pred   = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: compares whatever the stimulus side expects for this cycle
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("res_valid",  {31'd0, bus.res_valid},  {31'd0, e.valid});
            chk("taken",      {31'd0, bus.taken},      {31'd0, e.taken});
            chk("target",     bus.target,              e.target);
            chk("zero",       {31'd0, bus.zero},       {31'd0, e.zero});
            chk("one",        {31'd0, bus.one},        {31'd0, e.one});
            chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e.miss});
            chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, e.ill});
            chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.pred});
            chk("br_count",   {16'd0, bus.br_count},   {16'd0, e.brc});
            chk("miss_count", {16'd0, bus.miss_count}, {16'd0, e.mc});
        end
    end

    task automatic doReset();
        rst = 1'b1;
        bus.br_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        @(posedge clk);
        #1;
        {mValid, mTaken, mZero, mOne, mMiss, mIll} = '0;
        mTarget = '0;
        mBr = '0;
        mMc = '0;
        for (int i = 0; i < BHT_DEPTH; i++) mBht[i] = 2'b01;
        q.push_back(snapshot(bus.lookup_pc));
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus; expTaken/expTarget are hand-computed per vector
    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pcv, input logic [15:0] off,
                         input logic pin, input logic [31:0] look, input logic st,
                         input logic fl, input logic expTaken, input logic [31:0] expTarget);
        logic illegal;
        logic missN;
        bus.br_valid  = v;
        bus.br_op     = op;
        bus.op1       = a;
        bus.op2       = b;
        bus.pc        = pcv;
        bus.offset    = off;
        bus.pred_in   = pin;
        bus.lookup_pc = look;
        bus.stall     = st;
        bus.flush     = fl;
        @(posedge clk);
        #1;
        illegal = (op >= 3'd6);
`ifdef BRANCH_PRED_EN
        missN = expTaken ^ pin;
`else
        missN = expTaken;
`endif
        if (fl) begin
            {mValid, mTaken, mMiss, mIll} = '0;
        end else if (!st) begin
            mValid = v;
            if (v) begin
                mTaken  = expTaken;
                mTarget = expTarget;
                mZero   = (a == b);
                mOne    = (a != b);
                mMiss   = missN;
                mIll    = illegal;
                if (mBr != 16'hFFFF) mBr = mBr + 16'd1;
                if (missN && mMc != 16'hFFFF) mMc = mMc + 16'd1;
                if (!illegal) begin
                    if (expTaken && mBht[pcv[5:2]] != 2'b11) mBht[pcv[5:2]] = mBht[pcv[5:2]] + 2'b01;
                    else if (!expTaken && mBht[pcv[5:2]] != 2'b00) mBht[pcv[5:2]] = mBht[pcv[5:2]] - 2'b01;
                end
            end else begin
                {mTaken, mMiss, mIll} = '0;
            end
        end
        q.push_back(snapshot(look));
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] vals [3];
        logic [2:0]  t3 [4];
        vals[0] = 32'h8000_0000;
        vals[1] = 32'h0000_0000;
        vals[2] = 32'h0000_0001;
        // taken per value {0x80000000, 0, 1} for BLTZ, BGEZ, BLEZ, BGTZ
        t3[0] = 3'b100;
        t3[1] = 3'b011;
        t3[2] = 3'b110;
        t3[3] = 3'b001;

        bus.br_op = '0; bus.op1 = '0; bus.op2 = '0; bus.pc = '0;
        bus.offset = '0; bus.pred_in = 1'b0; bus.lookup_pc = 32'h100;
        doReset();

        // Equality compares
        drive(1, 3'd0, 5, 5, 32'h100, 16'd3, 0, 32'h100, 0, 0, 1, 32'h110);
        drive(1, 3'd1, 5, 5, 32'h100, 16'd3, 0, 32'h100, 0, 0, 0, 32'h110);
        drive(0, 3'd0, 0, 0, 32'h0,   16'd0, 0, 32'h100, 0, 0, 0, 32'h0);

        // Sign compares at negative, zero, positive
        for (int o = 0; o < 4; o++)
            for (int k = 0; k < 3; k++)
                drive(1, 3'(o + 2), vals[k], 0, 32'h200, 16'd0, k[0], 32'h200, 0, 0,
                      t3[o][2-k], 32'h204);

        // BHT training to saturation
        doReset();
        for (int n = 0; n < 4; n++)
            drive(1, 3'd0, 7, 7, 32'h40, 16'd0, 0, 32'h40, 0, 0, 1, 32'h44);

        // Stall hold, then flush beats stall, then plain flush
        drive(1, 3'd0, 1, 2, 32'h80, 16'hFFFF, 0, 32'h80, 0, 0, 0, 32'h80);
        for (int n = 0; n < 3; n++)
            drive(1, 3'd1, 3, 4, 32'h300, 16'd1, 0, 32'h300, 1, 0, 1, 32'h308);
        drive(1, 3'd1, 3, 4, 32'h300, 16'd1, 0, 32'h300, 1, 1, 1, 32'h308);
        drive(1, 3'd1, 3, 4, 32'h300, 16'd1, 0, 32'h300, 0, 1, 1, 32'h308);
        drive(1, 3'd1, 3, 4, 32'h300, 16'd1, 1, 32'h300, 0, 0, 1, 32'h308);

        // Negative offset wrap, then illegal op
        drive(1, 3'd0, 0, 0, 32'h10, 16'h8000, 0, 32'h10, 0, 0, 1, 32'hFFFE_0014);
        drive(1, 3'd7, 9, 9, 32'h10, 16'd0,    1, 32'h10, 0, 0, 0, 32'h14);
        drive(1, 3'd6, 1, 0, 32'h10, 16'd0,    0, 32'h10, 0, 0, 0, 32'h14);
        drive(0, 3'd0, 0, 0, 32'h0,  16'd0,    0, 32'h10, 0, 0, 0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
`default_nettype wire
